// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg -- shared types and constants for the parameterised arbiter.
//   arb_state_e      : FSM state type (two legal states, one-hot encoded so that
//                      illegal encodings exist and can be recovered from).
//   MODE_FIXED/MODE_RR : values of the arbiter 'mode' input.
//   DEFAULT_*        : default parameter values for arb_param / arb_rr_pick.
// -----------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b01,
        StGrant = 2'b10
    } arb_state_e;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int unsigned DEFAULT_NUM_REQ  = 4;
    localparam int unsigned DEFAULT_MAX_HOLD = 0;

endpackage

// File: rtl/arb_rr_pick.sv
// -----------------------------------------------------------------------------
// arb_rr_pick -- purely combinational winner selection.
//   req   : request vector, bit i from agent i
//   elig  : eligibility mask, a cleared bit removes that agent from the search
//   start : round-robin search start index
//   mode  : MODE_FIXED = lowest eligible index wins, MODE_RR = first eligible
//           index found searching upward from 'start' with wrap to 0
//   win   : index of the winner (0 when valid is low)
//   valid : at least one eligible requester
// -----------------------------------------------------------------------------
module arb_rr_pick
    import arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         elig,
    input  logic [$clog2(NUM_REQ)-1:0] start,
    input  logic                       mode,
    output logic [$clog2(NUM_REQ)-1:0] win,
    output logic                       valid
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] cand;
    // One spare bit so start + offset can exceed NUM_REQ-1 before the wrap.
    logic [IdW:0]       idx;

    always_comb begin
        cand  = req & elig;
        win   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (mode == MODE_RR) begin
                idx = {1'b0, start} + (IdW + 1)'(i);
            end else begin
                idx = (IdW + 1)'(i);
            end
            if (idx >= (IdW + 1)'(NUM_REQ)) begin
                idx = idx - (IdW + 1)'(NUM_REQ);
            end
            if (!valid && cand[idx[IdW-1:0]]) begin
                valid = 1'b1;
                win   = idx[IdW-1:0];
            end
        end
    end

endmodule

// File: rtl/arb_param.sv
// -----------------------------------------------------------------------------
// arb_param -- parameterised fixed-priority / round-robin arbiter with optional
// hold-time limit and one-arbitration exclusion of a timed-out owner.
//   clock     : rising-edge clock
//   reset     : asynchronous active-high reset
//   mode      : MODE_FIXED or MODE_RR, sampled only when arbitrating in idle
//   req       : request vector, bit i from agent i
//   gnt       : registered one-hot (or zero) grant
//   gnt_id    : index of granted agent, 0 when nothing is granted
//   gnt_valid : high exactly when gnt is non-zero
// Ownership is never pre-empted; a release always leaves at least one idle
// cycle before the next owner is granted.
// -----------------------------------------------------------------------------
module arb_param
    import arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = DEFAULT_NUM_REQ,
    parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       mode,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       gnt_valid
);

    localparam int unsigned IdW   = $clog2(NUM_REQ);
    localparam int unsigned HoldW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HoldW-1:0] HoldLimit = HoldW'(MAX_HOLD);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IdW-1:0]     id_q, id_d;
    logic               valid_q, valid_d;
    logic [IdW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [HoldW-1:0]   hold_q, hold_d;
    logic [NUM_REQ-1:0] excl_q, excl_d;
    // Blocks arbitration on the first edge after reset release, so the earliest
    // grant lands on the second edge.
    logic               armed_q;

    logic [IdW-1:0]     pick_win;
    logic               pick_valid;
    logic               timeout;

    arb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req   (req),
        .elig  (~excl_q),
        .start (rr_ptr_q),
        .mode  (mode),
        .win   (pick_win),
        .valid (pick_valid)
    );

    assign timeout = (MAX_HOLD != 0) && (hold_q == HoldLimit);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        id_d     = id_q;
        valid_d  = valid_q;
        rr_ptr_d = rr_ptr_q;
        hold_d   = hold_q;
        excl_d   = excl_q;

        case (state_q)
            StIdle: begin
                gnt_d   = '0;
                id_d    = '0;
                valid_d = 1'b0;
                if (armed_q) begin
                    // The exclusion applies to this one arbitration only.
                    excl_d = '0;
                    if (pick_valid) begin
                        state_d  = StGrant;
                        gnt_d    = NUM_REQ'(1) << pick_win;
                        id_d     = pick_win;
                        valid_d  = 1'b1;
                        rr_ptr_d = (pick_win == IdW'(NUM_REQ - 1)) ? '0 : pick_win + 1'b1;
                        // Counts the grant cycle that starts at this edge.
                        hold_d   = (MAX_HOLD != 0) ? HoldW'(1) : '0;
                    end
                end
            end

            StGrant: begin
                if (!req[id_q] || timeout) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                    id_d    = '0;
                    valid_d = 1'b0;
                    // A request drop coinciding with timeout is a normal release.
                    excl_d  = req[id_q] ? gnt_q : '0;
                end else if (MAX_HOLD != 0) begin
                    // Below the limit here, so this never wraps.
                    hold_d = hold_q + 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
                gnt_d   = '0;
                id_d    = '0;
                valid_d = 1'b0;
                hold_d  = '0;
                excl_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            gnt_q    <= '0;
            id_q     <= '0;
            valid_q  <= 1'b0;
            rr_ptr_q <= '0;
            hold_q   <= '0;
            excl_q   <= '0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            id_q     <= id_d;
            valid_q  <= valid_d;
            rr_ptr_q <= rr_ptr_d;
            hold_q   <= hold_d;
            excl_q   <= excl_d;
            armed_q  <= 1'b1;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = id_q;
    assign gnt_valid = valid_q;

endmodule

// File: tb/tb_arb_param.sv
// -----------------------------------------------------------------------------
// tb_arb_param -- directed bench for arb_param. Three instances share a clock:
//   u_dut0  : NUM_REQ=4,  MAX_HOLD=0
//   u_dut8  : NUM_REQ=4,  MAX_HOLD=8
//   u_dut16 : NUM_REQ=16, MAX_HOLD=0
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_arb_param;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst0 = 1'b1, rst8 = 1'b1, rst16 = 1'b1;
    logic        mode0 = 1'b0, mode8 = 1'b0, mode16 = 1'b0;
    logic [3:0]  req0 = '0, req8 = '0;
    logic [15:0] req16 = '0;
    logic [3:0]  gnt0, gnt8;
    logic [15:0] gnt16;
    logic [1:0]  id0, id8;
    logic [3:0]  id16;
    logic        vld0, vld8, vld16;

    int n_checks = 0;
    int n_errors = 0;

    arb_param #(.NUM_REQ(4), .MAX_HOLD(0)) u_dut0 (
        .clock(clock), .reset(rst0), .mode(mode0), .req(req0),
        .gnt(gnt0), .gnt_id(id0), .gnt_valid(vld0)
    );

    arb_param #(.NUM_REQ(4), .MAX_HOLD(8)) u_dut8 (
        .clock(clock), .reset(rst8), .mode(mode8), .req(req8),
        .gnt(gnt8), .gnt_id(id8), .gnt_valid(vld8)
    );

    arb_param #(.NUM_REQ(16), .MAX_HOLD(0)) u_dut16 (
        .clock(clock), .reset(rst16), .mode(mode16), .req(req16),
        .gnt(gnt16), .gnt_id(id16), .gnt_valid(vld16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    int seq4[5]  = '{0, 1, 2, 3, 0};
    int seq16[4] = '{0, 15, 0, 15};

    initial begin
        // Reset values of all instances
        step();
        check("rst_gnt0", 32'(gnt0), 0);
        check("rst_vld0", 32'(vld0), 0);
        check("rst_id0", 32'(id0), 0);
        check("rst_gnt8", 32'(gnt8), 0);
        check("rst_gnt16", 32'(gnt16), 0);
        check("rst_vld16", 32'(vld16), 0);

        // Fixed priority, req=1110, then drop the owner
        rst0 = 1'b0; mode0 = 1'b0; req0 = 4'b1110;
        step(); check("fx_arm_gnt", 32'(gnt0), 0);
        step(); check("fx_gnt1", 32'(gnt0), 32'b0010);
        check("fx_id1", 32'(id0), 1);
        check("fx_vld1", 32'(vld0), 1);
        req0 = 4'b1100;
        step(); check("fx_dead", 32'(gnt0), 0);
        check("fx_dead_vld", 32'(vld0), 0);
        step(); check("fx_gnt2", 32'(gnt0), 32'b0100);
        check("fx_id2", 32'(id0), 2);

        // Asynchronous reset mid-grant, then RR restart with req=1000
        #2 rst0 = 1'b1;
        #1 check("ar_gnt", 32'(gnt0), 0);
        check("ar_vld", 32'(vld0), 0);
        check("ar_id", 32'(id0), 0);
        step();
        rst0 = 1'b0; mode0 = 1'b1; req0 = 4'b1000;
        step(); check("ar_first_edge", 32'(gnt0), 0);
        step(); check("ar_second_edge", 32'(gnt0), 32'b1000);
        check("ar_id3", 32'(id0), 3);

        // Round robin, all requesting, each owner drops after 2 grant cycles
        rst0 = 1'b1; req0 = 4'b1111;
        step();
        rst0 = 1'b0;
        step(); check("rr_arm", 32'(gnt0), 0);
        foreach (seq4[k]) begin
            step();
            check("rr_gnt", 32'(gnt0), 32'(1) << seq4[k]);
            check("rr_id", 32'(id0), 32'(seq4[k]));
            // A mode change while granted must not disturb the owner.
            mode0 = 1'b0;
            step();
            check("rr_hold", 32'(gnt0), 32'(1) << seq4[k]);
            mode0 = 1'b1;
            req0 = 4'b1111 & ~(4'(1) << seq4[k]);
            step();
            check("rr_dead", 32'(gnt0), 0);
            req0 = 4'b1111;
        end
        req0 = '0;

        // MAX_HOLD=8, fixed, req=0011 constant
        rst8 = 1'b0; mode8 = 1'b0; req8 = 4'b0011;
        step(); check("h8_arm", 32'(gnt8), 0);
        for (int c = 0; c < 8; c++) begin
            step(); check("h8_a0", 32'(gnt8), 32'b0001);
        end
        step(); check("h8_gap0", 32'(gnt8), 0);
        for (int c = 0; c < 8; c++) begin
            step(); check("h8_a1", 32'(gnt8), 32'b0010);
        end
        step(); check("h8_gap1", 32'(gnt8), 0);
        step(); check("h8_back0", 32'(gnt8), 32'b0001);
        check("h8_back0_id", 32'(id8), 0);

        // MAX_HOLD=8, sole requester is excluded for one arbitration
        rst8 = 1'b1; req8 = 4'b0001;
        step();
        rst8 = 1'b0;
        step(); check("sx_arm", 32'(gnt8), 0);
        for (int c = 0; c < 8; c++) begin
            step(); check("sx_a0", 32'(gnt8), 32'b0001);
        end
        step(); check("sx_gap_a", 32'(gnt8), 0);
        step(); check("sx_gap_b", 32'(gnt8), 0);
        step(); check("sx_regrant", 32'(gnt8), 32'b0001);

        // Request drop coincident with timeout: no exclusion
        for (int c = 0; c < 7; c++) begin
            step(); check("co_a0", 32'(gnt8), 32'b0001);
        end
        req8 = 4'b0000;
        step(); check("co_gap", 32'(gnt8), 0);
        req8 = 4'b0001;
        step(); check("co_regrant", 32'(gnt8), 32'b0001);
        check("co_vld", 32'(vld8), 1);
        req8 = '0;

        // NUM_REQ=16, RR, req=8001 with one-cycle drops -> pointer wrap
        rst16 = 1'b0; mode16 = 1'b1; req16 = 16'h8001;
        step(); check("w16_arm", 32'(gnt16), 0);
        foreach (seq16[k]) begin
            step();
            check("w16_gnt", 32'(gnt16), 32'(1) << seq16[k]);
            check("w16_id", 32'(id16), 32'(seq16[k]));
            req16 = 16'h8001 & ~(16'(1) << seq16[k]);
            step();
            check("w16_dead", 32'(gnt16), 0);
            req16 = 16'h8001;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
